// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scan-code decoder: tracks held levels of ten game keys
// and handshakes each byte with the keyboard receiver.
module ps2_key_decoder #(
  parameter int unsigned PREFIX_TIMEOUT = 1000000
) (
  input  logic       clock50,
  input  logic       resetn,
  input  logic       scan_ready,
  input  logic [7:0] scan_code,
  output logic       read,
  output logic [9:0] key_state,
  output logic       key_event,
  output logic [7:0] last_code
);

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    WAIT_LOW
  } state_t;

  localparam logic [23:0] TMO = 24'(PREFIX_TIMEOUT);

  state_t      state;
  logic        ext;
  logic        brk;
  logic [23:0] timer;
  logic [23:0] timer_next;
  logic [9:0]  key_mask;
  logic [9:0]  keys_next;
  logic        accept;
  logic        is_e0;
  logic        is_f0;
  logic        pending;

  assign accept     = (state == IDLE) && scan_ready;
  assign is_e0      = (scan_code == 8'hE0);
  assign is_f0      = (scan_code == 8'hF0);
  assign pending    = ext || brk;
  assign timer_next = timer + 24'd1;

  // Only one bit can be hit; E0-prefixed and plain codes use separate tables.
  always_comb begin
    key_mask = '0;
    if (!ext) begin
      case (scan_code)
        8'h1D:   key_mask[0] = 1'b1;
        8'h1C:   key_mask[1] = 1'b1;
        8'h1B:   key_mask[2] = 1'b1;
        8'h23:   key_mask[3] = 1'b1;
        8'h29:   key_mask[8] = 1'b1;
        8'h14:   key_mask[9] = 1'b1;
        default: key_mask    = '0;
      endcase
    end else begin
      case (scan_code)
        8'h75:   key_mask[4] = 1'b1;
        8'h72:   key_mask[5] = 1'b1;
        8'h6B:   key_mask[6] = 1'b1;
        8'h74:   key_mask[7] = 1'b1;
        default: key_mask    = '0;
      endcase
    end
  end

  always_comb begin
    if (brk) begin
      keys_next = key_state & ~key_mask;
    end else begin
      keys_next = key_state | key_mask;
    end
  end

  always_ff @(posedge clock50 or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      read      <= 1'b0;
      key_event <= 1'b0;
      key_state <= '0;
      last_code <= '0;
      ext       <= 1'b0;
      brk       <= 1'b0;
      timer     <= '0;
    end else begin
      read      <= 1'b0;
      key_event <= 1'b0;
      case (state)
        IDLE: begin
          if (scan_ready) begin
            last_code <= scan_code;
            timer     <= '0;
            read      <= 1'b1;
            state     <= ACK;
            if (is_e0) begin
              ext <= 1'b1;
            end else if (is_f0) begin
              brk <= 1'b1;
            end else begin
              key_state <= keys_next;
              key_event <= (keys_next != key_state);
              ext       <= 1'b0;
              brk       <= 1'b0;
            end
          end
        end
        ACK: begin
          state <= WAIT_LOW;
        end
        WAIT_LOW: begin
          if (!scan_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
      // A byte accepted this cycle wins over an expiring prefix.
      if (!accept && pending) begin
        if (timer_next == TMO) begin
          ext   <= 1'b0;
          brk   <= 1'b0;
          timer <= '0;
        end else begin
          timer <= timer_next;
        end
      end
    end
  end

endmodule
